// File: rtl/cache_arb_pkg.sv
// Shared encodings for the cache/AXI-bridge arbiter: FSM states, owner ids and access types.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic {
    W_EMPTY = 1'b0,
    W_FULL  = 1'b1
  } wr_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

endpackage

// File: rtl/wr_line_buffer.sv
// One-entry data-cache write buffer; holds a line or uncached word until the bridge takes it.
module wr_line_buffer
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_req,
  input  logic [2:0]        in_type,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [3:0]        in_strb,
  input  logic [LINE_W-1:0] in_data,
  output logic              in_rdy,
  input  logic              out_rdy,
  output logic              full,
  output logic [2:0]        buf_type,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [3:0]        buf_strb,
  output logic [LINE_W-1:0] buf_data
);

  wr_state_e w_state_q, w_state_d;
  logic      load;

  always_comb begin
    w_state_d = w_state_q;
    load      = 1'b0;
    unique case (w_state_q)
      W_EMPTY: begin
        if (in_req) begin
          load      = 1'b1;
          w_state_d = W_FULL;
        end
      end
      W_FULL: begin
        if (out_rdy) w_state_d = W_EMPTY;
      end
      default: w_state_d = W_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= W_EMPTY;
      buf_type  <= '0;
      buf_addr  <= '0;
      buf_strb  <= '0;
      buf_data  <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (load) begin
        buf_type <= in_type;
        buf_addr <= in_addr;
        buf_strb <= in_strb;
        buf_data <= in_data;
      end
    end
  end

  assign in_rdy = (w_state_q == W_EMPTY);
  assign full   = (w_state_q == W_FULL);

endmodule

// File: rtl/cache_axi_arbiter.sv
// Arbitrates icache/dcache reads onto the bridge port and buffers one dcache write.
// Define ARB_RR_EN for round-robin read arbitration; default is fixed dcache-over-icache priority.
module cache_axi_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_rd_req,
  input  logic [2:0]        inst_rd_type,
  input  logic [ADDR_W-1:0] inst_rd_addr,
  output logic              inst_rd_rdy,
  output logic              inst_ret_valid,
  output logic              inst_ret_last,
  input  logic              data_rd_req,
  input  logic [2:0]        data_rd_type,
  input  logic [ADDR_W-1:0] data_rd_addr,
  output logic              data_rd_rdy,
  output logic              data_ret_valid,
  output logic              data_ret_last,
  output logic [31:0]       ret_data_o,
  input  logic              data_wr_req,
  input  logic [2:0]        data_wr_type,
  input  logic [ADDR_W-1:0] data_wr_addr,
  input  logic [3:0]        data_wr_strb,
  input  logic [LINE_W-1:0] data_wr_data,
  output logic              data_wr_rdy,
  output logic              rd_req,
  output logic [2:0]        rd_type,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_rdy,
  input  logic              ret_valid,
  input  logic              ret_last,
  input  logic [31:0]       ret_data,
  output logic              wr_req,
  output logic [2:0]        wr_type,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_strb,
  output logic [LINE_W-1:0] wr_data,
  input  logic              wr_rdy
);

  rd_state_e         r_state_q, r_state_d;
  logic              own_q, own_d;
  logic [2:0]        rtype_q, rtype_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              wb_full;
  logic              inst_elig, data_elig, grant, win_data;

  wr_line_buffer #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) u_wbuf (
    .clk      (clk),
    .resetn   (resetn),
    .in_req   (data_wr_req),
    .in_type  (data_wr_type),
    .in_addr  (data_wr_addr),
    .in_strb  (data_wr_strb),
    .in_data  (data_wr_data),
    .in_rdy   (data_wr_rdy),
    .out_rdy  (wr_rdy),
    .full     (wb_full),
    .buf_type (wr_type),
    .buf_addr (wr_addr),
    .buf_strb (wr_strb),
    .buf_data (wr_data)
  );

  assign wr_req = wb_full;

  // A dcache read may not overtake a buffered write to the same line.
  assign inst_elig = inst_rd_req;
  assign data_elig = data_rd_req &&
                     !(wb_full && (data_rd_addr[ADDR_W-1:4] == wr_addr[ADDR_W-1:4]));
  assign grant     = resetn && (r_state_q == R_IDLE) && (inst_elig || data_elig);

`ifdef ARB_RR_EN
  logic ptr_q;  // 1: dcache preferred

  assign win_data = data_elig && (ptr_q || !inst_elig);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    ptr_q <= OWN_DATA;
    else if (grant) ptr_q <= !win_data;
  end
`else
  assign win_data = data_elig;
`endif

  assign inst_rd_rdy = grant && !win_data;
  assign data_rd_rdy = grant && win_data;

  always_comb begin
    r_state_d = r_state_q;
    own_d     = own_q;
    rtype_d   = rtype_q;
    raddr_d   = raddr_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (grant) begin
          own_d     = win_data ? OWN_DATA : OWN_INST;
          rtype_d   = win_data ? data_rd_type : inst_rd_type;
          raddr_d   = win_data ? data_rd_addr : inst_rd_addr;
          r_state_d = R_REQ;
        end
      end
      R_REQ: begin
        if (rd_rdy) r_state_d = R_RESP;
      end
      R_RESP: begin
        if (ret_valid && ret_last) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      own_q     <= OWN_INST;
      rtype_q   <= '0;
      raddr_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      own_q     <= own_d;
      rtype_q   <= rtype_d;
      raddr_q   <= raddr_d;
    end
  end

  assign rd_req  = (r_state_q == R_REQ);
  assign rd_type = rtype_q;
  assign rd_addr = raddr_q;

  assign inst_ret_valid = (r_state_q == R_RESP) && (own_q == OWN_INST) && ret_valid;
  assign inst_ret_last  = (r_state_q == R_RESP) && (own_q == OWN_INST) && ret_last;
  assign data_ret_valid = (r_state_q == R_RESP) && (own_q == OWN_DATA) && ret_valid;
  assign data_ret_last  = (r_state_q == R_RESP) && (own_q == OWN_DATA) && ret_last;
  assign ret_data_o     = ret_data;

endmodule
